// File: rtl/streaming_row_compressor.sv
// Streams the non-zero words of an accepted row, one per beat, with column index and last flag.
// First beat one cycle after acceptance; beats hold under out_ready low; in_ready passes through on the final beat.
module streaming_row_compressor #(
   parameter int WORD_WIDTH = 8,
   parameter int ROW_SIZE   = 4,
   parameter int IDX_WIDTH  = 2,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WORD_WIDTH*ROW_SIZE-1:0] data_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WORD_WIDTH-1:0]          data_out,
   output logic [IDX_WIDTH-1:0]           idx_out,
   output logic                           last_out,
   output logic                           empty_row,
   output logic [CNT_WIDTH-1:0]           nz_count
);

   typedef enum logic [1:0] {IDLE, EMIT, ZERO} state_t;

   state_t                         state;
   logic [WORD_WIDTH*ROW_SIZE-1:0] row;
   logic [ROW_SIZE-1:0]            mask;

   logic                           fire;
   logic                           accept;
   logic [ROW_SIZE-1:0]            in_mask;
   logic [CNT_WIDTH-1:0]           in_cnt;
   logic [ROW_SIZE-1:0]            held_mask;
   logic [ROW_SIZE-1:0]            src_mask;
   logic [WORD_WIDTH*ROW_SIZE-1:0] src_row;
   logic [IDX_WIDTH-1:0]           nxt_idx;
   logic [WORD_WIDTH-1:0]          nxt_data;
   logic                           nxt_last;

   assign out_valid = (state != IDLE);

   always_comb begin
      fire     = out_valid && out_ready;
      in_ready = reset_n && ((state == IDLE) || (fire && last_out));
      accept   = in_valid && in_ready;
      in_mask  = '0;
      in_cnt   = '0;
      for (int i = 0; i < ROW_SIZE; i++) begin
         in_mask[i] = |data_in[i*WORD_WIDTH +: WORD_WIDTH];
         in_cnt     = in_cnt + CNT_WIDTH'(in_mask[i]);
      end
      held_mask = mask & ~(ROW_SIZE'(1) << idx_out);
      // The next beat is computed from either the freshly accepted row or the
      // held row minus the beat just handed off, so outputs can be registered.
      src_mask  = accept ? in_mask : held_mask;
      src_row   = accept ? data_in : row;
      nxt_idx   = '0;
      nxt_data  = '0;
      for (int i = ROW_SIZE - 1; i >= 0; i--) begin
         if (src_mask[i]) begin
            nxt_idx  = IDX_WIDTH'(i);
            nxt_data = src_row[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
      nxt_last = ((src_mask & (src_mask - ROW_SIZE'(1))) == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         row       <= '0;
         mask      <= '0;
         nz_count  <= '0;
         data_out  <= '0;
         idx_out   <= '0;
         last_out  <= 1'b0;
         empty_row <= 1'b0;
      end else if (accept) begin
         state     <= (|in_mask) ? EMIT : ZERO;
         row       <= data_in;
         mask      <= in_mask;
         nz_count  <= in_cnt;
         data_out  <= nxt_data;
         idx_out   <= nxt_idx;
         last_out  <= nxt_last;
         empty_row <= ~|in_mask;
      end else if (fire) begin
         if (last_out) begin
            state     <= IDLE;
            mask      <= '0;
            data_out  <= '0;
            idx_out   <= '0;
            last_out  <= 1'b0;
            empty_row <= 1'b0;
         end else begin
            mask     <= held_mask;
            data_out <= nxt_data;
            idx_out  <= nxt_idx;
            last_out <= nxt_last;
         end
      end
   end

endmodule

// File: tb/tb_streaming_row_compressor.sv
// Scoreboard bench: accepted rows expand into expected beats; a monitor pops and checks each presented beat.
module tb_streaming_row_compressor;
   localparam int W = 8;
   localparam int N = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   typedef struct {
      logic [W-1:0]  data;
      logic [IW-1:0] idx;
      logic          last;
      logic          empty;
      logic [CW-1:0] cnt;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W*N-1:0]  data_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [W-1:0]    data_out;
   logic [IW-1:0]   idx_out;
   logic            last_out;
   logic            empty_row;
   logic [CW-1:0]   nz_count;

   beat_t q[$];
   int checks = 0;
   int failures = 0;

   streaming_row_compressor #(.WORD_WIDTH(W), .ROW_SIZE(N), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .idx_out(idx_out),
      .last_out(last_out), .empty_row(empty_row), .nz_count(nz_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: list the non-zero words in index order; an all-zero row is one marker beat.
   task automatic push_row(input logic [W*N-1:0] r);
      int nz = 0;
      int seen = 0;
      logic [W-1:0] w;
      beat_t b;
      for (int i = 0; i < N; i++) begin
         w = r[i*W +: W];
         if (w != 0) nz++;
      end
      if (nz == 0) begin
         b.data = '0; b.idx = '0; b.last = 1'b1; b.empty = 1'b1; b.cnt = '0;
         q.push_back(b);
      end else begin
         for (int i = 0; i < N; i++) begin
            w = r[i*W +: W];
            if (w != 0) begin
               seen++;
               b.data = w; b.idx = IW'(i); b.last = (seen == nz); b.empty = 1'b0; b.cnt = CW'(nz);
               q.push_back(b);
            end
         end
      end
   endtask

   function automatic logic [W*N-1:0] mkrow(input int w0, input int w1, input int w2, input int w3);
      return {W'(w3), W'(w2), W'(w1), W'(w0)};
   endfunction

   function automatic logic [W*N-1:0] rand_row();
      logic [W*N-1:0] r;
      for (int i = 0; i < N; i++)
         r[i*W +: W] = ($urandom_range(0, 1) == 0) ? W'(0) : W'($urandom_range(1, 255));
      return r;
   endfunction

   // Recorder: rows are captured into the scoreboard only when the handshake completes.
   initial forever begin
      @(negedge clk);
      #2;
      if (reset_n && in_valid && in_ready) push_row(data_in);
   end

   // Monitor
   initial begin
      beat_t b;
      logic exp_rdy;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("in_ready", in_ready, exp_rdy);
            if (q.size() == 0) begin
               chk("unexpected_beat", out_valid, 1'b0);
            end else begin
               chk("out_valid", out_valid, 1'b1);
               if (out_valid) begin
                  b = q[0];
                  chk("data_out", data_out, b.data);
                  chk("idx_out", idx_out, b.idx);
                  chk("last_out", last_out, b.last);
                  chk("empty_row", empty_row, b.empty);
                  chk("nz_count", nz_count, b.cnt);
                  if (out_ready) void'(q.pop_front());
               end
            end
         end
      end
   end

   task automatic cycle(input logic v, input logic [W*N-1:0] d, input logic ordy);
      in_valid = v;
      data_in = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_data_out", data_out, 0);
      chk("rst_nz_count", nz_count, 0);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // [0,1,0,2]
      cycle(1, mkrow(0, 1, 0, 2), 1);
      repeat (3) cycle(0, rand_row(), 1);
      // zero row then [0,0,3,4] on the final-beat edge
      cycle(1, mkrow(0, 0, 0, 0), 1);
      cycle(1, mkrow(0, 0, 3, 4), 1);
      repeat (3) cycle(0, rand_row(), 1);
      // [5,6,0,7] stalled at beat 2 while in_valid pulses with a rejected row
      cycle(1, mkrow(5, 6, 0, 7), 1);
      cycle(0, rand_row(), 1);
      repeat (3) cycle(1, mkrow(9, 9, 9, 9), 0);
      repeat (3) cycle(0, rand_row(), 1);
      // back-to-back, no bubble
      cycle(1, mkrow(5, 6, 7, 8), 1);
      repeat (4) cycle(1, mkrow(0, 0, 8, 0), 1);
      repeat (2) cycle(0, rand_row(), 1);
      // full-width zero test
      cycle(1, mkrow(8'h80, 0, 8'h01, 0), 1);
      repeat (3) cycle(0, rand_row(), 1);

      // reset mid-row
      cycle(1, mkrow(0, 1, 0, 2), 1);
      cycle(0, rand_row(), 0);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_data_out", data_out, 0);
      chk("mid_rst_idx_out", idx_out, 0);
      chk("mid_rst_last_out", last_out, 1'b0);
      chk("mid_rst_nz_count", nz_count, 0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
      repeat (3) cycle(0, rand_row(), 1);

      // random traffic
      for (int n = 0; n < 400; n++)
         cycle($urandom_range(0, 9) < 7, rand_row(), $urandom_range(0, 9) < 7);

      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 40 && q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/streaming_row_compressor.md
# streaming_row_compressor

Sequential, handshaked successor to the combinational row compressor in the redundancy controller datapath. It accepts one row of ROW_SIZE packed words and emits only the non-zero words, one per beat, in ascending index order. Each beat carries the word's original column index and a last-of-row flag. It sits between the row buffer and the zero-skipping PE feed, and absorbs PE back-pressure.

## Interface
- WORD_WIDTH, 8, bits per word
- ROW_SIZE, 4, words per row (>= 2)
- IDX_WIDTH, 2, index width; must satisfy 2^IDX_WIDTH >= ROW_SIZE
- CNT_WIDTH, 3, count width; must satisfy 2^CNT_WIDTH > ROW_SIZE

- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  row on data_in is valid
- in_ready  output  1  block accepts a row this cycle
- data_in  input  WORD_WIDTH*ROW_SIZE  packed row; word i = data_in[WORD_WIDTH*(i+1)-1 : WORD_WIDTH*i]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- data_out  output  WORD_WIDTH  non-zero word, or 0 for an empty row
- idx_out  output  IDX_WIDTH  original column index of data_out
- last_out  output  1  final beat of the current row
- empty_row  output  1  current beat represents an all-zero row
- nz_count  output  CNT_WIDTH  number of non-zero words in the current row

## Operation
- Row acceptance occurs when in_valid && in_ready on a rising edge. At acceptance the block registers:
  - the row;
  - mask[i] = (word i != 0);
  - nz_count = popcount(mask).
- States:
  - IDLE: no row held.
  - EMIT: row held and mask != 0.
  - ZERO: row held and mask == 0.
- Transitions:
  - IDLE -> EMIT on acceptance with non-zero mask.
  - IDLE -> ZERO on acceptance with zero mask.
  - EMIT and ZERO: on the final beat handshake, go to IDLE. If a new row is accepted in the same cycle, go directly to EMIT or ZERO for the new row.
- EMIT beat contents:
  - data_out and idx_out come from the lowest set mask bit.
  - last_out = 1 when exactly one mask bit remains.
  - empty_row = 0.
  - On out_valid && out_ready, that mask bit clears.
- ZERO beat contents: single beat with data_out = 0, idx_out = 0, last_out = 1, empty_row = 1.
- in_ready = reset_n && (state == IDLE || (out_valid && last_out && out_ready)). This path from out_ready to in_ready is combinational, so back-to-back rows need no bubble.
- out_valid = (state != IDLE).
- While out_valid && !out_ready, data_out, idx_out, last_out, empty_row and nz_count hold stable.
- nz_count holds its value from acceptance until the next acceptance.
- Zero test is a full-width compare: any non-zero bit makes the word non-zero.

## Timing
- Reset (asynchronous, reset_n = 0):
  - state = IDLE, mask = 0;
  - out_valid, data_out, idx_out, last_out, empty_row, nz_count = 0;
  - in_ready = 0 while reset_n is low.
- Latency: a row accepted at edge N presents its first beat (out_valid = 1) after edge N.
- Throughput with out_ready held high: a row with k non-zeros takes k cycles (k >= 1); an all-zero row takes 1 cycle. There are no idle cycles between consecutive rows.
- Simultaneous final-beat handshake and new-row acceptance: both take effect on the same edge. The new row's first beat is presented after that edge.
- in_valid while in_ready = 0: ignored. data_in need not be held stable.
- reset_n asserted mid-row: the remaining beats are discarded. After release the block is in IDLE, and in_ready rises the same cycle reset_n goes high.

## Test plan
- Row [0,1,0,2] (word0 first), out_ready = 1:
  - beats (data 1, idx 1, last 0), then (data 2, idx 3, last 1);
  - nz_count = 2; in_ready = 1 during beat 2.
- Row [0,0,0,0]:
  - one beat, data 0, idx 0, last 1, empty_row 1, nz_count 0;
  - then row [0,0,3,4] accepted on the same edge, giving beats (3, idx 2), then (4, idx 3, last 1).
- Row [5,6,0,7] with out_ready low for 3 cycles at beat 2:
  - beat (6, idx 1) held stable throughout the stall;
  - in_ready = 0 throughout;
  - sequence 5, 6, 7 at idx 0, 1, 3.
- Back-to-back rows [5,6,7,8] and [0,0,8,0], in_valid and out_ready held high:
  - 5 consecutive valid beats: 5/0, 6/1, 7/2, 8/3 (last), then 8/2 (last);
  - no bubble between rows.
- Assert reset_n low after the first beat of [0,1,0,2]:
  - all outputs 0 immediately (asynchronous);
  - after release, no further beat appears until a new row is accepted.
- in_valid pulsed while in_ready = 0 in the middle of a row: the row is not captured, and beat order is unchanged.
